pipe_stage_reg: RTL and testbench

- Parametrised multi-lane pipeline stage register. It generalises the single-lane stage register between the memory and write-back stages.
- Sits between any two pipeline stages of the core. It keeps the core's stall-vector and flush protocol.
- Adds the following beyond the single-lane stage register:
  - per-lane valid bits
  - per-lane kill with younger-lane cascade, for dual-issue squash
  - optional payload zeroing
  - saturating performance counters (bubble, hold, retire)

---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register with stall/flush control, per-lane kill cascade
// and saturating bubble/hold/retire counters.
module pipe_stage_reg #(
    parameter int LANES         = 2,
    parameter int DATA_W        = 104,
    parameter int STALL_W       = 6,
    parameter int STAGE         = 4,
    parameter bit CLEAR_PAYLOAD = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_kill,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        hold_cnt,
    output logic [CNT_W-1:0]        retire_cnt
);

    localparam int SUM_W = CNT_W + 3;

    logic                    s_here;
    logic                    s_next;
    logic                    do_bubble;
    logic                    do_capture;
    logic                    do_hold;
    logic                    stall_unused;

    logic [LANES-1:0]        kill_cascade;
    logic [LANES-1:0]        cap_valid;
    logic [LANES-1:0]        valid_reg;
    logic [LANES-1:0]        valid_next;
    logic [LANES*DATA_W-1:0] data_reg;
    logic [LANES*DATA_W-1:0] data_next;

    logic [CNT_W-1:0]        bubble_reg;
    logic [CNT_W-1:0]        bubble_next;
    logic [CNT_W-1:0]        hold_reg;
    logic [CNT_W-1:0]        hold_next;
    logic [CNT_W-1:0]        retire_reg;
    logic [CNT_W-1:0]        retire_next;
    logic [CNT_W-1:0]        retire_sat;
    logic [2:0]              retire_add;
    logic [SUM_W-1:0]        retire_sum;

    // Only this stage's bit and the next one matter; the rest is folded away.
    assign stall_unused = ^stall;
    assign s_here       = stall[STAGE];

    generate
        if (STAGE == STALL_W - 1) begin : g_last_stage
            assign s_next = 1'b0;
        end else begin : g_mid_stage
            assign s_next = stall[STAGE+1];
        end
    endgenerate

    assign do_bubble  = !flush &&  s_here && !s_next;
    assign do_capture = !flush && !s_here;
    assign do_hold    = !flush &&  s_here &&  s_next;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign kill_cascade[gi] = in_kill[gi];
            end else begin : g_younger
                assign kill_cascade[gi] = kill_cascade[gi-1] | in_kill[gi];
            end

            assign cap_valid[gi]  = in_valid[gi] & ~kill_cascade[gi];
            assign valid_next[gi] = do_capture ? cap_valid[gi]
                                  : do_hold    ? valid_reg[gi]
                                  :              1'b0;

            // Any lane that ends up invalid (flush, bubble or killed) is zeroed or held.
            assign data_next[gi*DATA_W +: DATA_W] =
                (do_capture && cap_valid[gi])  ? in_data[gi*DATA_W +: DATA_W] :
                (!do_hold && CLEAR_PAYLOAD)    ? {DATA_W{1'b0}} :
                                                 data_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        retire_add = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            retire_add = retire_add + 3'(cap_valid[i]);
        end
    end

    assign retire_sum = {3'b000, retire_reg} + SUM_W'(retire_add);
    assign retire_sat = (retire_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                              : retire_sum[CNT_W-1:0];

    always_comb begin
        bubble_next = bubble_reg;
        hold_next   = hold_reg;
        retire_next = retire_reg;
        if (cnt_clr) begin
            bubble_next = '0;
            hold_next   = '0;
            retire_next = '0;
        end else begin
            if (do_bubble && (bubble_reg != {CNT_W{1'b1}})) begin
                bubble_next = bubble_reg + CNT_W'(1);
            end
            if (do_hold && (hold_reg != {CNT_W{1'b1}})) begin
                hold_next = hold_reg + CNT_W'(1);
            end
            if (do_capture) begin
                retire_next = retire_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg  <= '0;
            data_reg   <= '0;
            bubble_reg <= '0;
            hold_reg   <= '0;
            retire_reg <= '0;
        end else begin
            valid_reg  <= valid_next;
            data_reg   <= data_next;
            bubble_reg <= bubble_next;
            hold_reg   <= hold_next;
            retire_reg <= retire_next;
        end
    end

    assign out_valid  = valid_reg;
    assign out_data   = data_reg;
    assign bubble_cnt = bubble_reg;
    assign hold_cnt   = hold_reg;
    assign retire_cnt = retire_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (2-lane clearing, 1-lane holding at the last
// stall index) checked every cycle against a rule-level model plus directed literals.
module tb_pipe_stage_reg;

    localparam int A_CW = 4;
    localparam int B_CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [5:0]  a_stall;
    logic        a_flush, a_clr;
    logic [1:0]  a_iv, a_ik, a_ov;
    logic [63:0] a_id, a_od;
    logic [3:0]  a_bub, a_hold, a_ret;

    logic [5:0]  b_stall;
    logic        b_flush, b_clr;
    logic [0:0]  b_iv, b_ik, b_ov;
    logic [15:0] b_id, b_od;
    logic [15:0] b_bub, b_hold, b_ret;

    int tests = 0;
    int fails = 0;

    pipe_stage_reg #(
        .LANES(2), .DATA_W(32), .STALL_W(6), .STAGE(4), .CLEAR_PAYLOAD(1'b1), .CNT_W(A_CW)
    ) dut_a (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .in_valid(a_iv), .in_kill(a_ik), .in_data(a_id),
        .out_valid(a_ov), .out_data(a_od), .cnt_clr(a_clr),
        .bubble_cnt(a_bub), .hold_cnt(a_hold), .retire_cnt(a_ret)
    );

    pipe_stage_reg #(
        .LANES(1), .DATA_W(16), .STALL_W(6), .STAGE(5), .CLEAR_PAYLOAD(1'b0), .CNT_W(B_CW)
    ) dut_b (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush),
        .in_valid(b_iv), .in_kill(b_ik), .in_data(b_id),
        .out_valid(b_ov), .out_data(b_od), .cnt_clr(b_clr),
        .bubble_cnt(b_bub), .hold_cnt(b_hold), .retire_cnt(b_ret)
    );

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][31:0] d;
        logic [15:0]      bub;
        logic [15:0]      hold;
        logic [15:0]      ret;
    } mstate_t;

    mstate_t ma, mb;

    function automatic logic [15:0] sat(input int v, input int m);
        return 16'((v > m) ? m : v);
    endfunction

    // Applies one clock edge's rules directly: flush, bubble, capture, hold, then clear.
    function automatic mstate_t model_next(
        input mstate_t s, input int lanes, input bit cp, input int stage, input int cw,
        input logic [5:0] stall, input logic flush, input logic clr,
        input logic [3:0] iv, input logic [3:0] ik, input logic [3:0][31:0] id);
        mstate_t    n;
        logic [6:0] st;
        int         maxc, retired;
        bit         here, nxt, killed;
        n       = s;
        st      = {1'b0, stall};
        maxc    = (1 << cw) - 1;
        here    = st[stage];
        nxt     = st[stage+1];
        retired = 0;
        killed  = 1'b0;
        if (flush || (here && !nxt)) begin
            for (int i = 0; i < lanes; i++) begin
                n.v[i] = 1'b0;
                if (cp) n.d[i] = '0;
            end
            if (!flush) n.bub = sat(int'(s.bub) + 1, maxc);
        end else if (!here) begin
            for (int i = 0; i < lanes; i++) begin
                killed = killed | ik[i];
                n.v[i] = iv[i] & !killed;
                if (n.v[i]) begin
                    n.d[i] = id[i];
                    retired++;
                end else if (cp) begin
                    n.d[i] = '0;
                end
            end
            n.ret = sat(int'(s.ret) + retired, maxc);
        end else begin
            n.hold = sat(int'(s.hold) + 1, maxc);
        end
        if (clr) begin
            n.bub  = '0;
            n.hold = '0;
            n.ret  = '0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= model_next(ma, 2, 1'b1, 4, A_CW, a_stall, a_flush, a_clr,
                             {2'b00, a_iv}, {2'b00, a_ik}, {64'd0, a_id});
            mb <= model_next(mb, 1, 1'b0, 5, B_CW, b_stall, b_flush, b_clr,
                             {3'b000, b_iv}, {3'b000, b_ik}, {112'd0, b_id});
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model a_valid",  64'(a_ov),   64'(ma.v[1:0]));
        chk("model a_data",   a_od,        {ma.d[1], ma.d[0]});
        chk("model a_bubble", 64'(a_bub),  64'(ma.bub));
        chk("model a_hold",   64'(a_hold), 64'(ma.hold));
        chk("model a_retire", 64'(a_ret),  64'(ma.ret));
        chk("model b_valid",  64'(b_ov),   64'(mb.v[0]));
        chk("model b_data",   64'(b_od),   64'(mb.d[0][15:0]));
        chk("model b_bubble", 64'(b_bub),  64'(mb.bub));
        chk("model b_hold",   64'(b_hold), 64'(mb.hold));
        chk("model b_retire", 64'(b_ret),  64'(mb.ret));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        a_stall = '0; a_flush = 1'b0; a_clr = 1'b0; a_iv = '0; a_ik = '0; a_id = '0;
        b_stall = '0; b_flush = 1'b0; b_clr = 1'b0; b_iv = '0; b_ik = '0; b_id = '0;
        repeat (2) @(negedge clk);
        chk("reset valid", 64'(a_ov), 64'd0);
        chk("reset retire", 64'(a_ret), 64'd0);
        rst = 1'b1;

        // Reset and capture, including an asynchronous mid-cycle reset.
        a_iv = 2'b11; a_id = {32'h6, 32'h5};
        tick();
        chk("pre-reset valid", 64'(a_ov), 64'h3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async reset valid", 64'(a_ov), 64'd0);
        chk("async reset data", a_od, 64'd0);
        chk("async reset retire", 64'(a_ret), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        a_id = {32'h2, 32'h1};
        tick();
        chk("capture valid", 64'(a_ov), 64'h3);
        chk("capture data", a_od, {32'h2, 32'h1});
        chk("capture retire", 64'(a_ret), 64'd2);

        // Bubble, then hold with changing inputs, then capture under downstream stall.
        a_stall = 6'b010000;
        tick();
        chk("bubble valid", 64'(a_ov), 64'd0);
        chk("bubble data", a_od, 64'd0);
        chk("bubble count", 64'(a_bub), 64'd1);
        a_stall = 6'b000000; a_id = {32'h4, 32'h3};
        tick();
        a_stall = 6'b110000; a_id = {32'hDEAD, 32'hBEEF}; a_iv = 2'b01;
        repeat (3) tick();
        chk("hold data", a_od, {32'h4, 32'h3});
        chk("hold valid", 64'(a_ov), 64'h3);
        chk("hold count", 64'(a_hold), 64'd3);
        a_stall = 6'b100000; a_iv = 2'b11; a_id = {32'h8, 32'h7};
        tick();
        chk("next-stalled capture data", a_od, {32'h8, 32'h7});
        chk("next-stalled capture retire", 64'(a_ret), 64'd6);

        // Kill cascade.
        a_stall = 6'b000000; a_id = {32'hA, 32'h9}; a_ik = 2'b01;
        tick();
        chk("kill lane0 valid", 64'(a_ov), 64'd0);
        chk("kill lane0 data", a_od, 64'd0);
        chk("kill lane0 retire", 64'(a_ret), 64'd6);
        a_ik = 2'b10;
        tick();
        chk("kill lane1 valid", 64'(a_ov), 64'h1);
        chk("kill lane1 data", a_od, {32'h0, 32'h9});
        chk("kill lane1 retire", 64'(a_ret), 64'd7);
        a_iv = 2'b10; a_ik = 2'b01;
        tick();
        chk("kill invalid lane cascades", 64'(a_ov), 64'd0);
        a_ik = 2'b00; a_iv = 2'b11; a_id = {32'hC, 32'hB};
        tick();
        chk("refill retire", 64'(a_ret), 64'd9);

        // Flush wins over a hold pattern.
        a_flush = 1'b1; a_stall = 6'b110000;
        tick();
        chk("flush valid", 64'(a_ov), 64'd0);
        chk("flush data", a_od, 64'd0);
        chk("flush hold", 64'(a_hold), 64'd3);
        chk("flush bubble", 64'(a_bub), 64'd1);
        a_flush = 1'b0;

        // Counter saturation and clear.
        a_stall = 6'b010000; a_ik = 2'b11;
        repeat (20) tick();
        chk("bubble saturate", 64'(a_bub), 64'hF);
        a_ik = 2'b00; a_stall = 6'b000000; a_iv = 2'b11;
        repeat (2) tick();
        a_iv = 2'b01;
        tick();
        chk("retire at 14", 64'(a_ret), 64'd14);
        a_iv = 2'b11;
        tick();
        chk("retire clamp", 64'(a_ret), 64'hF);
        a_stall = 6'b010000; a_clr = 1'b1;
        tick();
        chk("clear bubble", 64'(a_bub), 64'd0);
        chk("clear retire", 64'(a_ret), 64'd0);
        a_clr = 1'b0; a_stall = 6'b000000; a_id = {32'hE, 32'hD};
        tick();
        a_stall = 6'b110000;
        repeat (17) tick();
        chk("hold saturate", 64'(a_hold), 64'hF);
        chk("hold long data", a_od, {32'hE, 32'hD});

        // Single lane, payload held, this stage is the last stall index.
        b_iv = 1'b1; b_id = 16'hABCD;
        tick();
        chk("b capture data", 64'(b_od), 64'hABCD);
        b_stall = 6'b100000; b_id = 16'h1111;
        tick();
        chk("b bubble valid", 64'(b_ov), 64'd0);
        chk("b bubble data held", 64'(b_od), 64'hABCD);
        chk("b bubble count", 64'(b_bub), 64'd1);
        b_stall = 6'b110000;
        tick();
        chk("b last stage never holds", 64'(b_hold), 64'd0);
        chk("b second bubble", 64'(b_bub), 64'd2);
        b_stall = 6'b000000; b_ik = 1'b1; b_id = 16'h2222;
        tick();
        chk("b killed data held", 64'(b_od), 64'hABCD);
        chk("b killed retire", 64'(b_ret), 64'd1);
        b_ik = 1'b0; b_id = 16'h1234;
        tick();
        chk("b recapture data", 64'(b_od), 64'h1234);
        b_flush = 1'b1;
        tick();
        chk("b flush valid", 64'(b_ov), 64'd0);
        chk("b flush data held", 64'(b_od), 64'h1234);
        b_flush = 1'b0; b_iv = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
